i2s_msb_receiver: RTL and testbench



---
 rtl/i2s_msb_receiver.sv | 226 ++++++++++++++++++++++
 tb/tb_i2s_msb_receiver.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_msb_receiver.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : i2s_msb_receiver
//  Description : Slave receiver for an MSB-justified I2S stream. Oversamples
//                bclk/lrclk/data in the clk_x4_i domain and writes each bit
//                into a 1-bit circular frame RAM (256 bits per page). It also
//                publishes the page index of the last fully received frame.
//  Revision    : 1.0 - initial release
// ============================================================================
module i2s_msb_receiver #(
   parameter int CIRC_BUF_BITS = 3,
   parameter int BCLK_TIMEOUT  = 64
) (
   input  logic                       clk_x4_i,
   input  logic                       rst_ni,
   input  logic                       rx_enable_i,
   input  logic                       i2s_bclk_i,
   input  logic                       i2s_lrclk_i,
   input  logic                       i2s_data_i,
   output logic [CIRC_BUF_BITS+7:0]   ram_write_addr_o,
   output logic                       ram_data_o,
   output logic                       ram_we_o,
   output logic [CIRC_BUF_BITS-1:0]   last_good_frame_idx_o,
   output logic                       rx_locked_o,
   output logic                       rx_error_o
);

   // Last count value of the bclk watchdog; reaching it without an edge trips.
   localparam logic [7:0]               c_TO_LAST   = 8'(BCLK_TIMEOUT - 1);
   // Writer starts one page ahead of the published index.
   localparam logic [CIRC_BUF_BITS-1:0] c_FRAME_ONE = CIRC_BUF_BITS'(1);

   typedef enum logic [1:0] {
      StIdle    = 2'd0,
      StHunt    = 2'd1,
      StReceive = 2'd2
   } state_t;

   state_t                      r_state;
   state_t                      w_state_next;

   logic                        r_bclk_s1, r_bclk_s2, r_bclk_s3;
   logic                        r_lrclk_s1, r_lrclk_s2;
   logic                        r_data_s1, r_data_s2;
   logic                        r_lr_prev;
   logic                        r_lr_prev_vld;
   logic [7:0]                  r_to_cnt;
   logic [7:0]                  r_bit_idx;
   logic [CIRC_BUF_BITS-1:0]    r_wr_frame;
   logic [CIRC_BUF_BITS+7:0]    r_addr;
   logic                        r_data;
   logic                        r_we;
   logic                        r_err;
   logic                        r_locked;
   logic [CIRC_BUF_BITS-1:0]    r_last_good;

   logic                        w_bclk_rise;
   logic                        w_wr_en;
   logic [7:0]                  w_wr_idx;
   logic                        w_err;
   logic                        w_start;
   logic                        w_adv;
   logic                        w_timeout_hit;
   logic                        w_cnt_clr;

   assign w_bclk_rise = r_bclk_s2 & ~r_bclk_s3;
   assign w_cnt_clr   = (r_state == StIdle) || !rx_enable_i || w_bclk_rise || w_timeout_hit;

   // Two-flop synchronizers for the external pins plus a bclk edge register.
   always_ff @(posedge clk_x4_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_bclk_s1  <= 1'b0;
         r_bclk_s2  <= 1'b0;
         r_bclk_s3  <= 1'b0;
         r_lrclk_s1 <= 1'b0;
         r_lrclk_s2 <= 1'b0;
         r_data_s1  <= 1'b0;
         r_data_s2  <= 1'b0;
      end else begin
         r_bclk_s1  <= i2s_bclk_i;
         r_bclk_s2  <= r_bclk_s1;
         r_bclk_s3  <= r_bclk_s2;
         r_lrclk_s1 <= i2s_lrclk_i;
         r_lrclk_s2 <= r_lrclk_s1;
         r_data_s1  <= i2s_data_i;
         r_data_s2  <= r_data_s1;
      end
   end

   // Remember lrclk at the previous bclk edge; a timeout forgets it so a
   // fresh high-then-low pair is needed before locking again.
   always_ff @(posedge clk_x4_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_lr_prev     <= 1'b0;
         r_lr_prev_vld <= 1'b0;
      end else if (w_bclk_rise) begin
         r_lr_prev     <= r_lrclk_s2;
         r_lr_prev_vld <= 1'b1;
      end else if (w_timeout_hit) begin
         r_lr_prev_vld <= 1'b0;
      end
   end

   // Watchdog: cycles elapsed since the last bclk edge while hunting/receiving.
   always_ff @(posedge clk_x4_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_to_cnt <= 8'd0;
      end else if (w_cnt_clr) begin
         r_to_cnt <= 8'd0;
      end else begin
         r_to_cnt <= r_to_cnt + 8'd1;
      end
   end

   // State register.
   always_ff @(posedge clk_x4_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state and per-edge decisions: lock on lrclk fall, check slot parity.
   always_comb begin
      w_state_next  = r_state;
      w_wr_en       = 1'b0;
      w_wr_idx      = r_bit_idx;
      w_err         = 1'b0;
      w_start       = 1'b0;
      w_adv         = 1'b0;
      w_timeout_hit = 1'b0;
      if (!rx_enable_i) begin
         w_state_next = StIdle;
      end else begin
         case (r_state)
            StIdle: begin
               w_state_next = StHunt;
            end
            StHunt: begin
               if (w_bclk_rise) begin
                  if (r_lr_prev_vld && r_lr_prev && !r_lrclk_s2) begin
                     w_wr_en      = 1'b1;
                     w_wr_idx     = 8'd0;
                     w_start      = 1'b1;
                     w_state_next = StReceive;
                  end
               end else if (r_to_cnt == c_TO_LAST) begin
                  w_timeout_hit = 1'b1;
                  w_err         = 1'b1;
               end
            end
            StReceive: begin
               if (w_bclk_rise) begin
                  if (r_lrclk_s2 == r_bit_idx[5]) begin
                     w_wr_en = 1'b1;
                     w_adv   = 1'b1;
                  end else begin
                     w_err        = 1'b1;
                     w_state_next = StHunt;
                  end
               end else if (r_to_cnt == c_TO_LAST) begin
                  w_timeout_hit = 1'b1;
                  w_err         = 1'b1;
                  w_state_next  = StHunt;
               end
            end
            default: begin
               w_state_next = StIdle;
            end
         endcase
      end
   end

   // Bit position and write page; an abandoned partial page is reused.
   always_ff @(posedge clk_x4_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_bit_idx  <= 8'd0;
         r_wr_frame <= c_FRAME_ONE;
      end else begin
         if (w_start) begin
            r_bit_idx <= 8'd1;
         end else if (w_adv) begin
            r_bit_idx <= r_bit_idx + 8'd1;
         end else if (w_err) begin
            r_bit_idx <= 8'd0;
         end
         if (w_adv && (r_bit_idx == 8'hFF)) begin
            r_wr_frame <= r_wr_frame + c_FRAME_ONE;
         end
      end
   end

   // Registered RAM port, status strobes and the published frame index.
   always_ff @(posedge clk_x4_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_addr      <= '0;
         r_data      <= 1'b0;
         r_we        <= 1'b0;
         r_err       <= 1'b0;
         r_locked    <= 1'b0;
         r_last_good <= '0;
      end else begin
         r_we     <= w_wr_en;
         r_err    <= w_err;
         r_locked <= (r_state == StReceive);
         if (w_wr_en) begin
            r_addr <= {r_wr_frame, w_wr_idx};
            r_data <= r_data_s2;
         end
         if (r_we && (r_addr[7:0] == 8'hFF)) begin
            r_last_good <= r_addr[CIRC_BUF_BITS+7:8];
         end
      end
   end

   assign ram_write_addr_o      = r_addr;
   assign ram_data_o            = r_data;
   assign ram_we_o              = r_we;
   assign last_good_frame_idx_o = r_last_good;
   assign rx_locked_o           = r_locked;
   assign rx_error_o            = r_err;

endmodule
`default_nettype wire

// File: tb/tb_i2s_msb_receiver.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_i2s_msb_receiver
//  Description : Self-checking bench for i2s_msb_receiver. A bit-level model
//                predicts every write, error pulse, lock level and frame
//                index at the clock cycle where it must appear.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_i2s_msb_receiver;

   localparam int CBB = 3;
   localparam int TO  = 64;
   localparam int NP  = 1 << CBB;
   localparam int N   = 65536;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             en;
   logic             bclk;
   logic             lrclk;
   logic             sdata;
   logic [CBB+7:0]   addr;
   logic             rdata;
   logic             we;
   logic [CBB-1:0]   lg;
   logic             locked;
   logic             err;

   i2s_msb_receiver #(
      .CIRC_BUF_BITS (CBB),
      .BCLK_TIMEOUT  (TO)
   ) dut (
      .clk_x4_i              (clk),
      .rst_ni                (rst_n),
      .rx_enable_i           (en),
      .i2s_bclk_i            (bclk),
      .i2s_lrclk_i           (lrclk),
      .i2s_data_i            (sdata),
      .ram_write_addr_o      (addr),
      .ram_data_o            (rdata),
      .ram_we_o              (we),
      .last_good_frame_idx_o (lg),
      .rx_locked_o           (locked),
      .rx_error_o            (err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_mis = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
      n_cmp++;
      if (obs !== want) begin
         n_mis++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, want, cyc);
      end
   endtask

   // Expectations indexed by the cycle in which they must be visible.
   bit             exp_we   [N];
   logic [CBB+7:0] exp_addr [N];
   bit             exp_data [N];
   bit             exp_err  [N];
   int             chk_lock [N];
   int             chk_lg   [N];

   // Bit-level receiver model: 0 idle, 1 hunting, 2 receiving.
   int m_mode     = 0;
   bit m_prev_lr  = 1'b0;
   bit m_prev_vld = 1'b0;
   int m_page     = 1;
   int m_idx      = 0;
   int m_lg       = 0;
   int m_last_due = 0;
   int n_exp_wr   = 0;
   int n_obs_wr   = 0;
   int g_pos      = 0;
   bit mon_on     = 1'b0;

   task automatic expect_write(input int due, input int idx, input bit d);
      exp_we[due]   = 1'b1;
      exp_addr[due] = (CBB+8)'(m_page * 256 + idx);
      exp_data[due] = d;
      chk_lock[due+1] = 1;
      n_exp_wr++;
   endtask

   // Any stretch longer than TO cycles without a bclk edge is a timeout.
   task automatic apply_timeouts(input int now_due);
      int x;
      if (m_mode != 0) begin
         while (now_due - m_last_due > TO) begin
            x = m_last_due + TO;
            exp_err[x]    = 1'b1;
            chk_lock[x+1] = 0;
            m_mode        = 1;
            m_prev_vld    = 1'b0;
            m_idx         = 0;
            m_last_due    = x;
         end
      end
   endtask

   task automatic model_rise(input bit lr, input bit d);
      int due = cyc + 3;
      apply_timeouts(due);
      if (m_mode == 1) begin
         if (m_prev_vld && m_prev_lr && !lr) begin
            expect_write(due, 0, d);
            m_idx  = 1;
            m_mode = 2;
         end else begin
            chk_lock[due+1] = 0;
         end
      end else if (m_mode == 2) begin
         if (int'(lr) == (m_idx / 32) % 2) begin
            expect_write(due, m_idx, d);
            if (m_idx == 255) begin
               chk_lg[due]   = m_lg;
               m_lg          = m_page;
               chk_lg[due+1] = m_lg;
               m_page        = (m_page + 1) % NP;
            end
            m_idx = (m_idx + 1) % 256;
         end else begin
            exp_err[due]    = 1'b1;
            chk_lock[due+1] = 0;
            m_mode          = 1;
            m_idx           = 0;
         end
      end
      m_prev_lr  = lr;
      m_prev_vld = 1'b1;
      m_last_due = due;
   endtask

   task automatic wait_cyc(input int n);
      apply_timeouts(cyc + n + 3);
      repeat (n) @(negedge clk);
   endtask

   // Data and lrclk change with the falling bclk edge, as a source would.
   task automatic drive_bit(input bit lr, input bit d, input int lo, input int hi);
      bclk  = 1'b0;
      lrclk = lr;
      sdata = d;
      wait_cyc(lo);
      bclk = 1'b1;
      model_rise(lr, d);
      wait_cyc(hi);
   endtask

   task automatic send(input int n, input bit rnd, input bit flip_first, input int first_lo);
      int pos, lo, hi;
      bit lr, d;
      for (int i = 0; i < n; i++) begin
         pos = g_pos % 256;
         lr  = bit'((pos >> 5) & 1);
         if (flip_first && i == 0) lr = ~lr;
         d   = rnd ? bit'($urandom % 2) : bit'(pos & 1);
         lo  = rnd ? int'($urandom_range(4, 2)) : 2;
         hi  = rnd ? int'($urandom_range(4, 2)) : 2;
         if (i == 0 && first_lo > 0) lo = first_lo;
         drive_bit(lr, d, lo, hi);
         g_pos++;
      end
   endtask

   task automatic set_enable(input bit v);
      int q = cyc;
      if (!v) begin
         apply_timeouts(q + 1);
         en            = 1'b0;
         chk_lock[q+2] = 0;
         m_mode        = 0;
      end else begin
         en         = 1'b1;
         m_mode     = 1;
         m_last_due = q + 1;
      end
   endtask

   // Cycle-by-cycle comparison of DUT outputs against the model.
   always @(negedge clk) begin
      if (mon_on) begin
         chk("we", 32'(we), 32'(exp_we[cyc]));
         if (exp_we[cyc]) begin
            chk("addr", 32'(addr), 32'(exp_addr[cyc]));
            chk("data", 32'(rdata), 32'(exp_data[cyc]));
         end
         if (we) n_obs_wr++;
         chk("err", 32'(err), 32'(exp_err[cyc]));
         if (chk_lock[cyc] >= 0) chk("locked", 32'(locked), 32'(chk_lock[cyc]));
         if (chk_lg[cyc] >= 0) chk("last_good", 32'(lg), 32'(chk_lg[cyc]));
      end
   end

   initial begin
      for (int i = 0; i < N; i++) begin
         chk_lock[i] = -1;
         chk_lg[i]   = -1;
      end
      rst_n = 1'b0;
      en    = 1'b0;
      bclk  = 1'b0;
      lrclk = 1'b0;
      sdata = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_we", 32'(we), 32'd0);
      chk("rst_addr", 32'(addr), 32'd0);
      chk("rst_data", 32'(rdata), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_locked", 32'(locked), 32'd0);
      chk("rst_last_good", 32'(lg), 32'd0);
      mon_on = 1'b1;
      rst_n  = 1'b1;
      @(negedge clk);
      wait_cyc(2);
      set_enable(1'b1);
      wait_cyc(3);

      // Stream joins mid-frame with lrclk high; pattern bit i = i[0], bclk = clk/4.
      g_pos = 230;
      send(2 * 256 + 46, 1'b0, 1'b0, 0);
      chk("two_frames_last_good", 32'(lg), 32'd2);

      // lrclk flipped at bit 40 of a frame: error, then relock on next fall.
      send((256 - g_pos % 256) % 256 + 40, 1'b1, 1'b0, 0);
      send(1, 1'b1, 1'b1, 0);
      send(300, 1'b1, 1'b0, 0);

      // bclk held low for 70 cycles mid-frame: timeout, then recovery.
      send(100, 1'b1, 1'b0, 0);
      send(1, 1'b1, 1'b0, 70);
      send(400, 1'b1, 1'b0, 0);

      // Enough frames to wrap the page index, then disable mid-frame.
      send(9 * 256 + 10, 1'b1, 1'b0, 0);
      send(37, 1'b1, 1'b0, 0);
      wait_cyc(3);
      set_enable(1'b0);
      send(50, 1'b1, 1'b0, 0);
      set_enable(1'b1);
      wait_cyc(3);
      send(300, 1'b1, 1'b0, 0);
      wait_cyc(10);

      chk("final_last_good", 32'(lg), 32'(m_lg));
      chk("write_count", 32'(n_obs_wr), 32'(n_exp_wr));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
`default_nettype wire
